// File: rtl/opt_scheduler.sv
// Sweep scheduler for the replica-exchange annealer: drives the shared move
// generator for every replica per sweep and inserts even/odd exchange phases.
package opt_scheduler_pkg;
   typedef enum logic [1:0] {THR = 2'd0, OR1 = 2'd1, TWO = 2'd2} opt_command_t;
endpackage

module opt_scheduler
   import opt_scheduler_pkg::*;
#(
   parameter int unsigned REPLICA_NUM       = 32,
   parameter int unsigned EXCHANGE_INTERVAL = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           abort,
   input  logic [15:0]                    sweep_num,
   input  logic [63:0]                    i_seed,
   output logic                           busy,
   output logic                           done,
   output logic [15:0]                    sweep_cnt,
   output logic                           rnd_init,
   output logic [63:0]                    rnd_seed,
   output logic                           rnd_run,
   output opt_command_t                   rnd_opt_com,
   input  logic                           rnd_ready,
   output logic                           dl_start,
   output logic [$clog2(REPLICA_NUM)-1:0] dl_replica,
   input  logic                           dl_done,
   output logic                           ex_start,
   output logic                           ex_parity,
   input  logic                           ex_done
);

   localparam int unsigned      REP_W         = $clog2(REPLICA_NUM);
   localparam logic [REP_W-1:0] REP_LAST      = REP_W'(REPLICA_NUM - 1);
   localparam logic [15:0]      EX_LAST       = 16'(EXCHANGE_INTERVAL - 1);
   localparam logic [63:0]      SEED_FALLBACK = 64'h0139_408D_CBBF_7A44;

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_RND, S_GUARD, S_RND_WAIT, S_EVAL, S_EVAL_WAIT,
      S_NEXT, S_EXCH, S_EXCH_WAIT, S_DONE
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [15:0]        r_sweep_num;
   logic [15:0]        r_sweep_cnt, w_sweep_cnt_nxt, w_sweep_inc;
   logic [15:0]        r_ex_cnt, w_ex_cnt_nxt;
   logic [REP_W-1:0]   r_rep, w_rep_nxt;
   logic               r_ex_parity, w_ex_parity_nxt;
   logic               w_accept, w_ex_hit;

   logic               r_busy, r_done, r_rnd_init, r_rnd_run, r_dl_start, r_ex_start;
   logic [63:0]        r_rnd_seed;
   opt_command_t       r_opt;
   logic [REP_W-1:0]   r_dl_replica;

   logic               w_busy, w_done, w_rnd_init, w_rnd_run, w_dl_start, w_ex_start;
   opt_command_t       w_opt;
   logic [REP_W-1:0]   w_dl_replica;

   assign w_accept    = (r_state == S_IDLE) && start;
   assign w_sweep_inc = r_sweep_cnt + 16'd1;
   // Running modulo counter instead of sweep_cnt % EXCHANGE_INTERVAL.
   assign w_ex_hit    = (r_ex_cnt == EX_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_sweep_num  <= '0;
         r_sweep_cnt  <= '0;
         r_ex_cnt     <= '0;
         r_rep        <= '0;
         r_ex_parity  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_rnd_init   <= 1'b0;
         r_rnd_seed   <= '0;
         r_rnd_run    <= 1'b0;
         r_opt        <= THR;
         r_dl_start   <= 1'b0;
         r_dl_replica <= '0;
         r_ex_start   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sweep_cnt  <= w_sweep_cnt_nxt;
         r_ex_cnt     <= w_ex_cnt_nxt;
         r_rep        <= w_rep_nxt;
         r_ex_parity  <= w_ex_parity_nxt;
         if (w_accept) begin
            r_sweep_num <= sweep_num;
            r_rnd_seed  <= (i_seed == '0) ? SEED_FALLBACK : i_seed;
         end
         r_busy       <= w_busy;
         r_done       <= w_done;
         r_rnd_init   <= w_rnd_init;
         r_rnd_run    <= w_rnd_run;
         r_opt        <= w_opt;
         r_dl_start   <= w_dl_start;
         r_dl_replica <= w_dl_replica;
         r_ex_start   <= w_ex_start;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_sweep_cnt_nxt = r_sweep_cnt;
      w_ex_cnt_nxt    = r_ex_cnt;
      w_rep_nxt       = r_rep;
      w_ex_parity_nxt = r_ex_parity;
      if (abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_state_nxt     = S_INIT;
                  w_sweep_cnt_nxt = '0;
                  w_ex_cnt_nxt    = '0;
                  w_rep_nxt       = '0;
                  w_ex_parity_nxt = 1'b0;
               end
            end
            S_INIT:      w_state_nxt = (r_sweep_num == '0) ? S_DONE : S_RND;
            S_RND:       w_state_nxt = S_GUARD;
            S_GUARD:     w_state_nxt = S_RND_WAIT;
            S_RND_WAIT:  if (rnd_ready) w_state_nxt = S_EVAL;
            S_EVAL:      w_state_nxt = S_EVAL_WAIT;
            S_EVAL_WAIT: if (dl_done) w_state_nxt = S_NEXT;
            S_NEXT: begin
               if (r_rep != REP_LAST) begin
                  w_rep_nxt   = r_rep + REP_W'(1);
                  w_state_nxt = S_RND;
               end else begin
                  w_rep_nxt       = '0;
                  w_sweep_cnt_nxt = w_sweep_inc;
                  w_ex_cnt_nxt    = w_ex_hit ? '0 : r_ex_cnt + 16'd1;
                  if (w_ex_hit)                         w_state_nxt = S_EXCH;
                  else if (w_sweep_inc == r_sweep_num)  w_state_nxt = S_DONE;
                  else                                  w_state_nxt = S_RND;
               end
            end
            S_EXCH:      w_state_nxt = S_EXCH_WAIT;
            S_EXCH_WAIT: begin
               if (ex_done) begin
                  w_ex_parity_nxt = ~r_ex_parity;
                  w_state_nxt     = (r_sweep_cnt == r_sweep_num) ? S_DONE : S_RND;
               end
            end
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so the registered copy lines up with the state.
   always_comb begin
      w_busy       = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      w_done       = (w_state_nxt == S_DONE);
      w_rnd_init   = (w_state_nxt == S_INIT);
      w_rnd_run    = (w_state_nxt == S_RND);
      w_dl_start   = (w_state_nxt == S_EVAL);
      w_ex_start   = (w_state_nxt == S_EXCH);
      w_dl_replica = (w_state_nxt == S_EVAL) ? r_rep : r_dl_replica;
      w_opt        = THR;
      if ((w_state_nxt == S_RND) || (w_state_nxt == S_GUARD) || (w_state_nxt == S_RND_WAIT))
         w_opt = w_sweep_cnt_nxt[0] ? OR1 : TWO;
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign sweep_cnt   = r_sweep_cnt;
   assign rnd_init    = r_rnd_init;
   assign rnd_seed    = r_rnd_seed;
   assign rnd_run     = r_rnd_run;
   assign rnd_opt_com = r_opt;
   assign dl_start    = r_dl_start;
   assign dl_replica  = r_dl_replica;
   assign ex_start    = r_ex_start;
   assign ex_parity   = r_ex_parity;

endmodule

// File: tb/tb_opt_scheduler.sv
// Scoreboard bench for opt_scheduler: the run model queues the expected strobe
// sequence, a monitor pops it, and randomized responders drive the handshakes.
module tb_opt_scheduler;
   import opt_scheduler_pkg::*;

   localparam int R  = 4;
   localparam int EI = 2;
   localparam logic [63:0] SEED_FB = 64'h0139_408D_CBBF_7A44;
   localparam int K_INIT = 0, K_RUN = 1, K_DL = 2, K_EX = 3, K_DONE = 4;

   typedef struct {
      int           kind;
      int           rep;
      opt_command_t opt;
      int           par;
      int           sweep;
      logic [63:0]  seed;
      int           lat;
   } ev_t;

   logic         clk, reset, start, abort, start_main, spur_start;
   logic [15:0]  sweep_num;
   logic [63:0]  i_seed;
   logic         busy, done, rnd_init, rnd_run, dl_start, ex_start, ex_parity;
   logic [15:0]  sweep_cnt;
   logic [63:0]  rnd_seed;
   opt_command_t rnd_opt_com;
   logic         rnd_ready, dl_done, ex_done;
   logic [1:0]   dl_replica;

   int           checks = 0;
   int           errors = 0;
   ev_t          q[$];
   bit           run_active = 0, pending = 0, spur_en = 0, abort_ex = 0;
   opt_command_t exp_opt = THR;
   int           obs = 0, last_ev_obs = 0, last_sweep = 0;
   int           gen_cnt = 0, dl_cnt = 0, ex_cnt = 0;

   assign start = start_main | spur_start;

   opt_scheduler #(.REPLICA_NUM(R), .EXCHANGE_INTERVAL(EI)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .sweep_num(sweep_num), .i_seed(i_seed), .busy(busy), .done(done),
      .sweep_cnt(sweep_cnt), .rnd_init(rnd_init), .rnd_seed(rnd_seed),
      .rnd_run(rnd_run), .rnd_opt_com(rnd_opt_com), .rnd_ready(rnd_ready),
      .dl_start(dl_start), .dl_replica(dl_replica), .dl_done(dl_done),
      .ex_start(ex_start), .ex_parity(ex_parity), .ex_done(ex_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic finish_bench();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   task automatic push_ev(input int kind, input int rep, input opt_command_t opt,
                          input int par, input int sweep, input logic [63:0] seed, input int lat);
      ev_t e;
      e.kind = kind; e.rep = rep; e.opt = opt; e.par = par;
      e.sweep = sweep; e.seed = seed; e.lat = lat;
      q.push_back(e);
   endtask

   // Whole-run reference: every replica every sweep, exchange every EI sweeps.
   task automatic model_run(input int s_num, input logic [63:0] seed);
      int par = 0;
      push_ev(K_INIT, 0, THR, 0, 0, (seed == 64'd0) ? SEED_FB : seed, -1);
      for (int s = 0; s < s_num; s++) begin
         for (int r = 0; r < R; r++) begin
            push_ev(K_RUN, 0, (s % 2 == 1) ? OR1 : TWO, 0, s, 64'd0, (s == 0 && r == 0) ? 1 : -1);
            push_ev(K_DL, r, THR, 0, s, 64'd0, -1);
         end
         if ((s + 1) % EI == 0) begin
            push_ev(K_EX, 0, THR, par, s + 1, 64'd0, -1);
            par ^= 1;
         end
      end
      push_ev(K_DONE, 0, THR, 0, s_num, 64'd0, (s_num == 0) ? 1 : -1);
   endtask

   task automatic monitor_cycle();
      int  n;
      int  kind;
      ev_t e;
      n = int'(rnd_init) + int'(rnd_run) + int'(dl_start) + int'(ex_start) + int'(done);
      if (pending && rnd_ready) pending = 0;
      if (n > 1) begin
         chk("strobe_overlap", 64'(n), 64'(1));
      end else if (n == 1) begin
         kind = rnd_init ? K_INIT : rnd_run ? K_RUN : dl_start ? K_DL : ex_start ? K_EX : K_DONE;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual_kind=%0d required=none at %0t", kind, $time);
         end else begin
            e = q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            chk("sweep_cnt", 64'(sweep_cnt), 64'(e.sweep));
            if (e.lat >= 0) chk("event_latency", 64'(obs - last_ev_obs), 64'(e.lat));
            case (e.kind)
               K_INIT: begin
                  chk("rnd_seed", rnd_seed, e.seed);
                  chk("init_after_start", 64'(start_main), 64'(1));
                  run_active = 1;
               end
               K_RUN: begin
                  chk("opt_at_run", 64'(rnd_opt_com), 64'(e.opt));
                  pending = 1;
                  exp_opt = e.opt;
               end
               K_DL:   chk("dl_replica", 64'(dl_replica), 64'(e.rep));
               K_EX:   chk("ex_parity", 64'(ex_parity), 64'(e.par));
               default: run_active = 0;
            endcase
            last_ev_obs = obs;
            last_sweep  = e.sweep;
         end
      end
      if (!rnd_run) chk("opt_hold", 64'(rnd_opt_com), 64'(pending ? exp_opt : THR));
      if (!done) chk("busy", 64'(busy), 64'(run_active));
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            q.delete();
            run_active = 0;
            pending    = 0;
         end else if (abort && run_active) begin
            chk("abort_busy", 64'(busy), 64'(0));
            chk("abort_done", 64'(done), 64'(0));
            chk("abort_strobes", 64'({rnd_init, rnd_run, dl_start, ex_start}), 64'(0));
            chk("abort_opt", 64'(rnd_opt_com), 64'(THR));
            chk("abort_sweep_hold", 64'(sweep_cnt), 64'(last_sweep));
            q.delete();
            run_active = 0;
            pending    = 0;
         end else begin
            monitor_cycle();
         end
         obs++;
      end
   end

   // Handshake responders, with dropped spurious pulses on the other inputs.
   initial begin
      rnd_ready = 0; dl_done = 0; ex_done = 0; spur_start = 0; abort = 0;
      forever begin
         @(negedge clk);
         rnd_ready = 0; dl_done = 0; ex_done = 0; spur_start = 0; abort = 0;
         if (!reset) begin
            gen_cnt = 0; dl_cnt = 0; ex_cnt = 0;
         end else begin
            if (gen_cnt > 0) begin
               gen_cnt--;
               if (gen_cnt == 0) rnd_ready = 1;
               else if (gen_cnt == 1 && spur_en && $urandom_range(0, 1) == 1) dl_done = 1;
            end
            if (dl_cnt > 0) begin
               dl_cnt--;
               if (dl_cnt == 0) dl_done = 1;
               else if (dl_cnt == 1 && spur_en && $urandom_range(0, 1) == 1) begin
                  spur_start = 1;
                  rnd_ready  = 1;
               end
            end
            if (ex_cnt > 0) begin
               ex_cnt--;
               if (ex_cnt == 0) begin
                  if (abort_ex) abort = 1;
                  else          ex_done = 1;
               end
            end
            if (rnd_run)  gen_cnt = 3 + int'($urandom_range(0, 3));
            if (dl_start) dl_cnt  = 1 + int'($urandom_range(0, 3));
            if (ex_start) ex_cnt  = 1 + int'($urandom_range(0, 3));
         end
      end
   end

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_sweep_cnt"}, 64'(sweep_cnt), 64'(0));
      chk({tag, "_rnd_init"}, 64'(rnd_init), 64'(0));
      chk({tag, "_rnd_seed"}, rnd_seed, 64'(0));
      chk({tag, "_rnd_run"}, 64'(rnd_run), 64'(0));
      chk({tag, "_opt"}, 64'(rnd_opt_com), 64'(THR));
      chk({tag, "_dl_start"}, 64'(dl_start), 64'(0));
      chk({tag, "_dl_replica"}, 64'(dl_replica), 64'(0));
      chk({tag, "_ex_start"}, 64'(ex_start), 64'(0));
      chk({tag, "_ex_parity"}, 64'(ex_parity), 64'(0));
   endtask

   task automatic start_run(input int s_num, input logic [63:0] seed);
      @(negedge clk);
      sweep_num = 16'(s_num);
      i_seed    = seed;
      model_run(s_num, seed);
      start_main = 1;
      @(negedge clk);
      start_main = 0;
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      do begin
         @(posedge clk);
         #2;
         t++;
      end while ((q.size() != 0 || run_active) && t < budget);
      if (q.size() != 0 || run_active) begin
         checks++;
         errors++;
         $display("FAIL run_timeout pending_events=%0d required=0", q.size());
         finish_bench();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic reset_mid_rnd_wait();
      int t = 0;
      while (!rnd_run && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!rnd_run) begin
         checks++;
         errors++;
         $display("FAIL wait_rnd_run actual=timeout required=pulse");
         finish_bench();
      end
      @(negedge clk);
      @(posedge clk);
      #2;
      reset = 0;
      #1;
      check_reset_values("async_reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset = 0; start_main = 0; sweep_num = '0; i_seed = '0;
      #3;
      check_reset_values("reset");
      repeat (2) @(negedge clk);
      reset = 1;
      @(negedge clk);

      start_run(2, 64'd1);
      wait_idle(5000);
      spur_en = 1;
      start_run(4, {$urandom, $urandom});
      wait_idle(5000);
      start_run(1, 64'd0);
      wait_idle(5000);
      start_run(0, {$urandom, $urandom});
      wait_idle(5000);

      abort_ex = 1;
      start_run(3, {$urandom, $urandom});
      wait_idle(5000);
      abort_ex = 0;

      start_run(3, {$urandom, $urandom});
      reset_mid_rnd_wait();

      for (int i = 0; i < 4; i++) begin
         start_run(int'($urandom_range(1, 7)), {$urandom, $urandom});
         wait_idle(8000);
      end
      finish_bench();
   end

endmodule
